// File: rtl/seq_add_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// State encoding and index-width helper used by the controller.
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_add_ctrl_if.sv
// Operand/result handshake bundle for seq_add_ctrl.
// master = source/consumer side, slave = the adder controller.
interface seq_add_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry, busy
    );
endinterface

// File: rtl/seq_add_ctrl_slice.sv
// Combinational CHUNK-bit ripple-carry slice made of 1-bit full adders.
// Shared by every pass of the sequential adder.
module add_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[CHUNK];
endmodule

// File: rtl/seq_add_ctrl.sv
// Sequential WIDTH-bit adder: one CHUNK-bit slice per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_add_ctrl_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_w(NCHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_add_ctrl: WIDTH must be a multiple of CHUNK");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cy;
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    assign w_last = (r_idx == IW'(NCHUNK - 1));
    assign w_x    = r_opa[int'(r_idx)*CHUNK +: CHUNK];
    assign w_y    = r_opb[int'(r_idx)*CHUNK +: CHUNK];

    add_slice #(.CHUNK(CHUNK)) u_slice (
        .x  (w_x),
        .y  (w_y),
        .ci (r_cy),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        unique case (r_state)
            IDLE: w_in_ready = 1'b1;
            RUN:  w_busy     = 1'b1;
            DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operands are captured once; the slice mux walks them by r_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == IDLE) begin
            if (bus.in_valid) begin
                r_opa <= bus.a;
                r_opb <= bus.b;
                r_cy  <= bus.cin;
                r_idx <= '0;
            end
        end else if (r_state == RUN) begin
            r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_s;
            r_cy <= w_co;
            if (w_last) begin
                r_carry <= w_co;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;
endmodule

// File: tb/tb_seq_add_ctrl.sv
// Bench for seq_add_ctrl: directed vectors on CHUNK=8 and CHUNK=32
// instances, then randomised handshake traffic against a 33-bit add.
module tb_seq_add_ctrl;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_add_ctrl_if #(.WIDTH(32)) if8 ();
    seq_add_ctrl_if #(.WIDTH(32)) if32 ();

    seq_add_ctrl #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    seq_add_ctrl #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32)
    );

    virtual seq_add_ctrl_if #(.WIDTH(32)) v8;
    virtual seq_add_ctrl_if #(.WIDTH(32)) v32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic op(virtual seq_add_ctrl_if #(.WIDTH(32)) vif,
                      input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic ci,
                      input logic [31:0] es, input logic ec,
                      input int elat, input int hold);
        int lat;
        @(negedge clk);
        vif.a         = a;
        vif.b         = b;
        vif.cin       = ci;
        vif.in_valid  = 1'b1;
        vif.out_ready = 1'b0;
        @(posedge clk);
        #1;
        vif.in_valid = 1'b0;
        vif.a        = ~a;
        vif.b        = 32'h5a5a_a5a5;
        vif.cin      = ~ci;
        check($sformatf("%s/rdy_lo", tag), vif.in_ready, 0);
        lat = 0;
        while (!vif.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s/lat", tag), lat, elat);
        check($sformatf("%s/sum", tag), vif.sum, es);
        check($sformatf("%s/carry", tag), vif.carry, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s/hold_ov", tag), vif.out_valid, 1);
            check($sformatf("%s/hold_sum", tag), {vif.carry, vif.sum},
                  {ec, es});
            check($sformatf("%s/hold_ir", tag), vif.in_ready, 0);
        end
        vif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        vif.out_ready = 1'b0;
        check($sformatf("%s/post_ov", tag), vif.out_valid, 0);
        check($sformatf("%s/post_ir", tag), vif.in_ready, 1);
    endtask

    task automatic rnd(virtual seq_add_ctrl_if #(.WIDTH(32)) vif,
                       input string tag, input int n);
        logic [32:0] q[$];
        logic [32:0] e;
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            vif.in_valid  = ($urandom_range(0, 1) == 1);
            vif.out_ready = ($urandom_range(0, 1) == 1);
            vif.a         = $urandom;
            vif.b         = $urandom;
            vif.cin       = ($urandom_range(0, 1) == 1);
            #1;
            if (vif.in_valid && vif.in_ready)
                q.push_back({1'b0, vif.a} + {1'b0, vif.b} + 33'(vif.cin));
            if (vif.out_valid && vif.out_ready) begin
                check($sformatf("%s/q_nonempty", tag), q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check(tag, {vif.carry, vif.sum}, e);
                end
                got++;
            end
        end
        if (got < n) check($sformatf("%s/timeout", tag), got, n);
        vif.in_valid  = 1'b0;
        vif.out_ready = 1'b0;
    endtask

    initial begin
        v8  = if8;
        v32 = if32;
        if8.in_valid   = 1'b0;
        if8.out_ready  = 1'b0;
        if8.a          = '0;
        if8.b          = '0;
        if8.cin        = 1'b0;
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b0;
        if32.a         = '0;
        if32.b         = '0;
        if32.cin       = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst/ir", if8.in_ready, 1);
        check("rst/ov", if8.out_valid, 0);
        check("rst/busy", if8.busy, 0);
        check("rst/sum", {if8.carry, if8.sum}, 0);

        op(v8, "basic", 32'd100, 32'd55, 1'b0, 32'd155, 1'b0, 4, 0);
        op(v8, "ff_p1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 4, 0);
        op(v8, "ff_ci", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 4, 0);
        op(v8, "mixed", 32'h00FF_00FF, 32'h0001_0001, 1'b1,
           32'h0100_0101, 1'b0, 4, 0);
        op(v8, "bp", 32'h8000_0000, 32'h8000_0001, 1'b1,
           32'h2, 1'b1, 4, 5);

        @(negedge clk);
        if8.a        = 32'd5;
        if8.b        = 32'd6;
        if8.cin      = 1'b0;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        check("mid/busy", if8.busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid/ov", if8.out_valid, 0);
        check("mid/sum", if8.sum, 0);
        check("mid/carry", if8.carry, 0);
        check("mid/ir", if8.in_ready, 1);
        check("mid/busy0", if8.busy, 0);
        op(v8, "after_rst", 32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 4, 0);

        op(v32, "w32_ff", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1, 0);
        op(v32, "w32_mix", 32'h00FF_00FF, 32'h0001_0001, 1'b1,
           32'h0100_0101, 1'b0, 1, 2);

        fork
            rnd(v8, "rnd8", 1000);
            rnd(v32, "rnd32", 1000);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
